// File: rtl/hist_eq_pkg.sv
// Shared types and widths for the histogram-equalization divider.
// The width constants here describe the build configuration used by hist_eq_divider.
package hist_eq_pkg;

  localparam int CDF_W_DEF      = 16;
  localparam int PIX_W_DEF      = 8;
  localparam int NUM_PIXELS_DEF = 64;

  localparam int NUM_W = CDF_W_DEF + PIX_W_DEF;
  localparam int CNT_W = $clog2(NUM_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // d * (2^PIX_W - 1) without a multiplier.
  function automatic logic [NUM_W-1:0] scale_num(input logic [NUM_W-1:0] d);
    return (d << PIX_W_DEF) - d;
  endfunction

endpackage

// File: rtl/hist_eq_div_core.sv
// Unsigned radix-2 restoring divider: NUM_W iterations, one quotient bit per cycle, MSB first.
// done_o pulses for one cycle once quot_o holds the final quotient.
module hist_eq_div_core #(
  parameter int NUM_W = 24,
  parameter int DEN_W = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [NUM_W-1:0] num_i,
  input  logic [DEN_W-1:0] den_i,
  output logic             done_o,
  output logic [NUM_W-1:0] quot_o
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] num_q, quot_q;
  logic [DEN_W-1:0] den_q, rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q, done_q;

  logic [DEN_W:0] trial, diff;
  logic           ge;

  assign trial = {rem_q, num_q[NUM_W-1]};
  assign diff  = trial - {1'b0, den_q};
  assign ge    = (trial >= {1'b0, den_q});

  always_ff @(posedge clk) begin
    if (reset) begin
      num_q  <= '0;
      den_q  <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        num_q  <= num_i;
        den_q  <= den_i;
        rem_q  <= '0;
        quot_q <= '0;
        cnt_q  <= '0;
        run_q  <= 1'b1;
      end else if (run_q) begin
        // Remainder stays below den, so it always fits back in DEN_W bits.
        num_q  <= num_q << 1;
        rem_q  <= ge ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
        quot_q <= {quot_q[NUM_W-2:0], ge};
        cnt_q  <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NUM_W - 1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign quot_o = quot_q;

endmodule

// File: rtl/hist_eq_divider.sv
// Maps a CDF value to g = ((cdf_in-cdf_min)*(2^PIX_W-1))/(NUM_PIXELS-cdf_min); HIST_EQ_ROUND_EN selects round-half-up.
// States: IDLE accepting | CALC dividing (or one-cycle fast result) | DONE holding g_out until out_ready.
module hist_eq_divider
  import hist_eq_pkg::*;
#(
  parameter int CDF_W      = CDF_W_DEF,
  parameter int PIX_W      = PIX_W_DEF,
  parameter int NUM_PIXELS = NUM_PIXELS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CDF_W-1:0] cdf_in,
  input  logic [CDF_W-1:0] cdf_min,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] g_out,
  output logic             div_zero,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [PIX_W-1:0] g_q, g_d;
  logic             dz_q, dz_d;
  logic             fast_q, fast_d;
  logic             start;

  logic [CDF_W-1:0] d_diff;
  logic [CDF_W:0]   den_u;
  logic             den_pos;
  logic [NUM_W-1:0] num, num_div, quot;
  logic             core_done;

  assign d_diff  = cdf_in - cdf_min;
  assign den_u   = (CDF_W+1)'(NUM_PIXELS) - {1'b0, cdf_min};
  assign den_pos = !den_u[CDF_W] && (den_u != '0);
  assign num     = scale_num(NUM_W'(d_diff));

`ifdef HIST_EQ_ROUND_EN
  assign num_div = num + NUM_W'(den_u >> 1);
`else
  assign num_div = num;
`endif

  hist_eq_div_core #(
    .NUM_W (NUM_W),
    .DEN_W (CDF_W + 1)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .start_i (start),
    .num_i   (num_div),
    .den_i   (den_u),
    .done_o  (core_done),
    .quot_o  (quot)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      g_q     <= '0;
      dz_q    <= 1'b0;
      fast_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      dz_q    <= dz_d;
      fast_q  <= fast_d;
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    dz_d    = dz_q;
    fast_d  = fast_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CALC;
          // A degenerate image (cdf_min >= NUM_PIXELS) wins over the zero-gap case.
          if (!den_pos) begin
            g_d    = '1;
            dz_d   = 1'b1;
            fast_d = 1'b1;
          end else if (cdf_in <= cdf_min) begin
            g_d    = '0;
            dz_d   = 1'b0;
            fast_d = 1'b1;
          end else begin
            dz_d   = 1'b0;
            fast_d = 1'b0;
            start  = 1'b1;
          end
        end
      end
      CALC: begin
        if (fast_q) begin
          state_d = DONE;
        end else if (core_done) begin
          state_d = DONE;
          g_d     = (|quot[NUM_W-1:PIX_W]) ? '1 : quot[PIX_W-1:0];
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign g_out     = g_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_hist_eq_divider.sv
// Directed and random transactions against an arithmetic model of the equalization mapping.
module tb_hist_eq_divider;

  localparam int CDF_W      = 16;
  localparam int PIX_W      = 8;
  localparam int NUM_PIXELS = 64;
  localparam int G_MAX      = (1 << PIX_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [CDF_W-1:0] cdf_in;
  logic [CDF_W-1:0] cdf_min;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] g_out;
  logic             div_zero;
  logic             busy;

  int checks = 0;
  int errors = 0;

  hist_eq_divider #(
    .CDF_W      (CDF_W),
    .PIX_W      (PIX_W),
    .NUM_PIXELS (NUM_PIXELS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cdf_in    (cdf_in),
    .cdf_min   (cdf_min),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .g_out     (g_out),
    .div_zero  (div_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int ci, input int cm, output int g, output int dz, output int lat);
    longint n, q;
    int den;
    den = NUM_PIXELS - cm;
    if (den <= 0) begin
      g = G_MAX; dz = 1; lat = 1;
    end else if (ci <= cm) begin
      g = 0; dz = 0; lat = 1;
    end else begin
      n = longint'(ci - cm) * G_MAX;
`ifdef HIST_EQ_ROUND_EN
      n = n + den / 2;
`endif
      q = n / den;
      g = (q > G_MAX) ? G_MAX : int'(q);
      dz = 0;
      lat = CDF_W + PIX_W + 1;
    end
  endfunction

  task automatic run_txn(input int ci, input int cm, input int hold, input string tag);
    int g_exp, dz_exp, lat_exp, n;
    model(ci, cm, g_exp, dz_exp, lat_exp);
    @(negedge clk);
    in_valid = 1'b1;
    cdf_in   = CDF_W'(ci);
    cdf_min  = CDF_W'(cm);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cdf_in   = CDF_W'($urandom);
    cdf_min  = CDF_W'($urandom);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
    end
    check({tag, "_latency"}, 32'(n), 32'(lat_exp));
    check({tag, "_g_out"}, 32'(g_out), 32'(g_exp));
    check({tag, "_div_zero"}, 32'(div_zero), 32'(dz_exp));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_g"}, 32'(g_out), 32'(g_exp));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int ci, cm, n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cdf_in    = '0;
    cdf_min   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_g_out", 32'(g_out), 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    run_txn(64, 1, 0, "full_scale");
    run_txn(33, 1, 0, "mid");
    run_txn(5, 5, 0, "eq_min");
    run_txn(3, 5, 0, "below_min");
    run_txn(64, 64, 0, "den_zero");
    run_txn(64, 70, 0, "den_neg");
    run_txn(200, 1, 0, "saturate");
    run_txn(50, 1, 10, "stall");
    run_txn(10, 2, 0, "b2b_a");
    run_txn(20, 2, 0, "b2b_b");
    run_txn(63, 0, 0, "b2b_c");

    // Abort a division five cycles into CALC.
    @(negedge clk);
    in_valid = 1'b1;
    cdf_in   = 16'd40;
    cdf_min  = 16'd1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    n = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) n++;
    end
    check("abort_no_output", 32'(n), 32'd0);
    run_txn(40, 1, 0, "after_abort");

    for (int k = 0; k < 24; k++) begin
      cm = int'($urandom_range(0, 80));
      ci = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 100)) : int'($urandom_range(0, 65535));
      run_txn(ci, cm, int'($urandom_range(0, 3)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
